// File: rtl/imem_fetch_sequencer_if.sv
// Fetch-side bus of the instruction fetch sequencer: control inputs,
// the memory address/data pair and the registered instruction outputs.
interface imem_fetch_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    // Upstream control, memory model and decode stage
    modport master (
        output start, start_addr, stall, redirect_valid, redirect_addr, imem_data,
        input  imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
    );

    // The sequencer itself
    modport slave (
        input  start, start_addr, stall, redirect_valid, redirect_addr, imem_data,
        output imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the async-read
// instruction memory every cycle, registers each fetched word for decode,
// honours stall/redirect and halts on the memory's invalid-address word.
//
// state | meaning
// IDLE  | after reset, waiting for start; PC parked at 0
// RUN   | fetching one word per non-stalled cycle
// HALT  | halt/invalid opcode seen; PC holds offending address until start
module imem_fetch_sequencer #(
    parameter int          ADDR_W  = 7,
    parameter int          DATA_W  = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111,
    parameter int          CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    imem_fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic [CNT_W-1:0]  fetch_count_q;
    logic              is_halt_word;

    // The memory address comes straight from the PC register; no data path feeds it.
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = fetch_count_q;

    assign is_halt_word = (bus.imem_data[DATA_W-1 -: 6] == HALT_OP);

    // Fetch FSM with all outputs registered; redirect beats stall beats halt detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        pc            <= bus.start_addr;
                        instr_valid_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        // One-cycle bubble while the new target is read.
                        pc            <= bus.redirect_addr;
                        instr_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        if (is_halt_word) begin
                            state         <= HALT;
                            halted_q      <= 1'b1;
                            instr_valid_q <= 1'b0;
                        end else begin
                            instr_q       <= bus.imem_data;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            pc            <= pc + 1'b1;
                            if (fetch_count_q != {CNT_W{1'b1}})
                                fetch_count_q <= fetch_count_q + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state    <= RUN;
                        pc       <= bus.start_addr;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed program walk, stall/redirect/halt
// corner cases, async reset, randomized traffic against a behavioural model,
// and fetch counter saturation on a narrow-counter instance.
module tb_imem_fetch_sequencer;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] mem [0:63];

    imem_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    imem_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4))     bus_s ();

    imem_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    imem_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    always #5 clk = ~clk;

    // Memory map: lower half holds the program, upper half reads as the halt word.
    assign bus.imem_data   = bus.imem_addr[6]   ? 32'hFC00_0000 : mem[bus.imem_addr[5:0]];
    assign bus_s.imem_data = bus_s.imem_addr[6] ? 32'hFC00_0000 : mem[bus_s.imem_addr[5:0]];

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;
    mstate_t     m_state;
    logic [6:0]  m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;
    int          m_count;

    function automatic logic [31:0] mem_rd(input logic [6:0] a);
        return (a >= 7'd64) ? 32'hFC00_0000 : mem[a[5:0]];
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_pc = 0; m_ipc = 0; m_instr = 0;
        m_valid = 0; m_halted = 0; m_count = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        w = mem_rd(m_pc);
        case (m_state)
            M_IDLE: if (bus.start) begin
                m_state = M_RUN; m_pc = bus.start_addr; m_valid = 0;
            end
            M_RUN: begin
                if (bus.redirect_valid) begin
                    m_pc = bus.redirect_addr; m_valid = 0;
                end else if (bus.stall) begin
                    // everything holds
                end else if ((w >> 26) == 32'd63) begin
                    m_state = M_HALT; m_halted = 1; m_valid = 0;
                end else begin
                    m_instr = w; m_ipc = m_pc; m_valid = 1;
                    m_pc = 7'((int'(m_pc) + 1) % 128);
                    if (m_count < CNT_MAX) m_count = m_count + 1;
                end
            end
            default: if (bus.start) begin
                m_state = M_RUN; m_pc = bus.start_addr; m_halted = 0;
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
        chk("instr",       bus.instr,            m_instr);
        chk("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("halted",      32'(bus.halted),      32'(m_halted));
        chk("fetch_count", 32'(bus.fetch_count), 32'(m_count));
    endtask

    // One clock: model updates on the edge, both compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic st, input logic [6:0] sa, input logic sl,
                         input logic rv, input logic [6:0] ra);
        bus.start = st; bus.start_addr = sa; bus.stall = sl;
        bus.redirect_valid = rv; bus.redirect_addr = ra;
    endtask

    initial begin
        // 21-word lw/add/sub/and/xor/slt/beq/j program, then filler with opcode[5] clear
        mem[0]  = 32'h8C10_0000; mem[1]  = 32'h8C11_0004; mem[2]  = 32'h0211_9020;
        mem[3]  = 32'h0211_9822; mem[4]  = 32'h0211_A024; mem[5]  = 32'h0211_A826;
        mem[6]  = 32'h0211_B02A; mem[7]  = 32'h1211_0002; mem[8]  = 32'h0211_9020;
        mem[9]  = 32'h8C12_0008; mem[10] = 32'h0232_9820; mem[11] = 32'h0253_A022;
        mem[12] = 32'h0274_A824; mem[13] = 32'h0200_B827; mem[14] = 32'h0211_C02A;
        mem[15] = 32'h1000_0003; mem[16] = 32'h0295_C826; mem[17] = 32'h8C13_000C;
        mem[18] = 32'h0273_D020; mem[19] = 32'h0800_0000; mem[20] = 32'h0000_0000;
        for (int i = 21; i < 64; i++) mem[i] = $urandom & 32'h7FFF_FFFF;

        bus_s.start = 0; bus_s.start_addr = 0; bus_s.stall = 0;
        bus_s.redirect_valid = 0; bus_s.redirect_addr = 0;
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        tick(); tick();
        chk("rst_valid",  32'(bus.instr_valid), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_addr",   32'(bus.imem_addr), 0);
        reset = 1'b0;
        // redirect/stall ignored in IDLE
        drive(0, 0, 1, 1, 7'd33);
        tick();
        chk("idle_ignore", 32'(bus.imem_addr), 0);

        // program walk from 0
        drive(1, 0, 0, 0, 0);
        tick();
        chk("valid_after_start", 32'(bus.instr_valid), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("first_valid", 32'(bus.instr_valid), 1);
        chk("first_pc",    32'(bus.instr_pc), 0);
        tick();
        tick();
        chk("pc2_pc",    32'(bus.instr_pc), 2);
        chk("pc2_instr", bus.instr, 32'h0211_9020);
        tick(); tick();
        chk("cnt_after5", 32'(bus.fetch_count), 5);

        // stall three cycles at instr_pc=4
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    32'(bus.instr_pc), 4);
            chk("stall_valid", 32'(bus.instr_valid), 1);
        end
        drive(0, 0, 0, 0, 0);
        tick(); chk("unstall_pc5", 32'(bus.instr_pc), 5);
        tick(); chk("unstall_pc6", 32'(bus.instr_pc), 6);
        tick(); tick();
        chk("pc_is_9", 32'(bus.imem_addr), 9);

        // redirect together with stall
        drive(0, 0, 1, 1, 7'd13);
        tick();
        chk("redir_bubble", 32'(bus.instr_valid), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("redir_pc",    32'(bus.instr_pc), 13);
        chk("redir_instr", bus.instr, 32'h0200_B827);

        // redirect into the invalid upper half
        drive(0, 0, 0, 1, 7'd100);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("redir100_halted", 32'(bus.halted), 1);
        chk("redir100_addr",   32'(bus.imem_addr), 100);
        drive(0, 0, 1, 1, 7'd5);
        tick();
        chk("halt_ignore", 32'(bus.imem_addr), 100);

        // sequential run off the end of the program area
        drive(1, 7'd62, 0, 0, 0);
        tick();
        chk("restart_halted", 32'(bus.halted), 0);
        drive(0, 0, 0, 0, 0);
        tick(); chk("seq_pc62", 32'(bus.instr_pc), 62);
        tick(); chk("seq_pc63", 32'(bus.instr_pc), 63);
        tick();
        chk("seq_halted", 32'(bus.halted), 1);
        chk("seq_valid",  32'(bus.instr_valid), 0);
        chk("seq_addr",   32'(bus.imem_addr), 64);
        drive(1, 0, 0, 0, 0);
        tick();
        chk("resume_halted", 32'(bus.halted), 0);
        drive(1, 7'd40, 0, 0, 0);
        tick();
        chk("resume_pc0", 32'(bus.instr_pc), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("start_in_run_ignored", 32'(bus.instr_pc), 1);

        // redirect on the cycle the halt word is presented
        drive(0, 0, 0, 1, 7'd62);
        tick();
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        chk("at_64", 32'(bus.imem_addr), 64);
        drive(0, 0, 0, 1, 7'd5);
        tick();
        chk("redir_beats_halt", 32'(bus.halted), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("redir_beats_halt_pc", 32'(bus.instr_pc), 5);

        // asynchronous reset mid-run
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 0);
        chk("arst_instr", bus.instr, 0);
        chk("arst_ipc",   32'(bus.instr_pc), 0);
        chk("arst_cnt",   32'(bus.fetch_count), 0);
        chk("arst_addr",  32'(bus.imem_addr), 0);
        model_reset();
        tick();
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) == 0,
                  ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 63)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  ($urandom_range(0, 4) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63)));
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);

        // counter saturation on the 4-bit instance (all-ones = 15)
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("sat_cnt", 32'(bus_s.fetch_count), (k > 15) ? 32'd15 : 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences the 128-entry x 32-bit asynchronous-read instruction memory.
- Owns the program counter and drives the memory word address every cycle.
- Registers each fetched word for the decode stage, and accepts stall and redirect (branch/jump resolved downstream) requests.
- Detects the memory's invalid-address word (opcode 6'b111111, returned for addr[6]==1) and halts fetch.

Parameters:
- ADDR_W, 7, word-address width of the instruction memory.
- DATA_W, 32, instruction width.
- HALT_OP, 6'b111111, opcode field value treated as halt/invalid.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetch at start_addr (honoured in IDLE and HALT only).
- start_addr  in  ADDR_W  first fetch address on start.
- stall  in  1  decode not ready; hold all outputs and PC.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse from the execute stage.
- redirect_addr  in  ADDR_W  new word address for redirect.
- imem_addr  out  ADDR_W  word address to the instruction memory; combinational copy of the internal PC.
- imem_data  in  DATA_W  instruction memory read data, same cycle as imem_addr.
- instr  out  DATA_W  registered fetched instruction.
- instr_pc  out  ADDR_W  address that instr was fetched from.
- instr_valid  out  1  instr/instr_pc are valid this cycle.
- halted  out  1  sequencer is in HALT.
- fetch_count  out  CNT_W  number of instructions delivered, saturating.

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-run:
  - state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
  - Reset is effective immediately; no partial fetch survives it.
- States: IDLE, RUN, HALT.
- IDLE:
  - imem_addr = PC (0).
  - start -> RUN, PC<=start_addr, instr_valid<=0.
  - redirect and stall are ignored.
- RUN, evaluated at each rising edge in this priority order:
  1. redirect_valid=1 (overrides stall): PC<=redirect_addr, instr_valid<=0 (one-cycle bubble), instr and instr_pc hold.
  2. stall=1: PC, instr, instr_pc, instr_valid and fetch_count all hold.
  3. imem_data[31:26]==HALT_OP: state<=HALT, halted<=1, instr_valid<=0, PC holds (points at the offending address), instr not updated.
  4. Otherwise: instr<=imem_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1 (modulo 2^ADDR_W, so 127 wraps to 0), fetch_count<=fetch_count+1, saturating at all-ones.
- Latency: the word at PC appears on instr one cycle after PC is presented; sustained throughput is one instruction per cycle with no stall.
- A start pulse while in RUN is ignored.
- HALT:
  - halted=1, instr_valid=0, imem_addr=PC.
  - stall and redirect are ignored.
  - start -> RUN, PC<=start_addr, halted<=0. fetch_count is kept, not cleared.
- Consequences of the memory map:
  - Sequential fetch past address 63 reaches address 64, reads the halt word, and halts.
  - A redirect to any address >=64 halts on the next non-stalled cycle.
- Simultaneous events:
  - redirect+stall: redirect wins.
  - redirect in the cycle whose fetched word is the halt word: the redirect wins and no halt occurs.
- imem_addr is purely combinational from the PC register, with no logic on imem_data in that path. The only combinational input-to-output path in the block is PC to imem_addr.

Test Plan:
- Reset then start, start_addr=0, memory loaded with the 21-word lw/add/sub/and/xor/slt/beq/j program: instr_valid rises 1 cycle after start. instr_pc runs 0,1,2,... each cycle. instr at pc=2 is 0x02119020 (add s2,s0,s1). fetch_count=5 after 5 valid cycles.
- stall held high for 3 cycles while instr_pc=4: instr, instr_pc=4 and instr_valid=1 all hold. On release, the next outputs are instr_pc=5, 6 with no skipped or duplicated word.
- redirect_valid with redirect_addr=13 while PC=9, asserted together with stall: next cycle instr_valid=0. The following cycle instr_pc=13, instr=0x0200B827 (nor s7,s0,$zero).
- Sequential run from start_addr=62: valid words at 62 and 63, then halted=1, instr_valid=0, imem_addr=64. A later start with start_addr=0 resumes and halted=0.
- Redirect to addr 100 (addr[6]=1, memory returns 0xFC000000): halt on the following cycle. Asserting reset mid-RUN clears all outputs immediately, without waiting for a clock edge.
- Preload fetch_count near all-ones (long run, or force 0xFFFE) and fetch 3 more words: fetch_count saturates at 0xFFFF and does not wrap.
